sample_gen: RTL and testbench

- Generates the `sample_adc` strobe consumed by the acquisition front end's edge detector, i.e. the transmitting end of the sample-trigger interface.
- Produces a programmable-period square wave with 50 % duty: continuous or a fixed-length burst.
- Every rising edge of `sample_adc` requests exactly one ADC conversion downstream.
- Sits between the control/register block and the sample edge detector.

---
 rtl/sample_gen.sv | 98 +++++++++
 tb/tb_sample_gen.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sample_gen.sv
// sample_gen: programmable-period 50% duty sample_adc strobe, continuous or burst.
// Define SAMPLE_GEN_EXT_TRIG_EN to add a synchronised ext_trig start source.
module sample_gen #(
   parameter int CNT_W   = 16,
   parameter int BURST_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic [CNT_W-1:0]   half_period,
   input  logic [BURST_W-1:0] burst_len,
`ifdef SAMPLE_GEN_EXT_TRIG_EN
   input  logic               ext_trig,
`endif
   output logic               sample_adc,
   output logic               busy,
   output logic               done,
   output logic [BURST_W-1:0] pulse_cnt
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t             r_state, w_next;
   logic [CNT_W-1:0]   r_cnt, r_hp, w_hp;
   logic [BURST_W-1:0] r_burst, r_pulse_cnt;
   logic               r_stop_pend, r_done, r_sample, r_busy;
   logic               w_go, w_zero, w_end, w_done, w_trig;

`ifdef SAMPLE_GEN_EXT_TRIG_EN
   logic r_sync1, r_sync2, r_sync3;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) {r_sync3, r_sync2, r_sync1} <= 3'b000;
      else     {r_sync3, r_sync2, r_sync1} <= {r_sync2, r_sync1, ext_trig};
   end

   assign w_trig = r_sync2 & ~r_sync3;
`else
   assign w_trig = 1'b0;
`endif

   assign w_hp   = (half_period == '0) ? CNT_W'(1) : half_period;
   assign w_go   = (r_state == IDLE) & (start | w_trig) & ~stop;
   assign w_zero = (r_cnt == '0);
   assign w_end  = r_stop_pend | (r_burst != '0 && r_pulse_cnt == r_burst);

   always_comb begin
      w_next = r_state;
      w_done = 1'b0;
      case (r_state)
         IDLE:    w_next = w_go ? HIGH : IDLE;
         HIGH:    w_next = w_zero ? LOW : HIGH;
         LOW: begin
            w_next = !w_zero ? LOW : (w_end ? IDLE : HIGH);
            w_done = w_zero & w_end;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_hp        <= '0;
         r_burst     <= '0;
         r_pulse_cnt <= '0;
         r_stop_pend <= 1'b0;
         r_done      <= 1'b0;
         r_sample    <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_done      <= w_done;
         r_sample    <= (w_next == HIGH);
         r_busy      <= (w_next != IDLE);
         // a start accepted with stop is impossible, so pend only ever arms while running
         r_stop_pend <= (w_next == IDLE) ? 1'b0 : (r_stop_pend | stop);
         if (w_go) begin
            r_hp        <= w_hp;
            r_burst     <= burst_len;
            r_pulse_cnt <= BURST_W'(1);
            r_cnt       <= w_hp - CNT_W'(1);
         end else if (r_state != IDLE) begin
            r_cnt <= w_zero ? r_hp - CNT_W'(1) : r_cnt - CNT_W'(1);
         end
         if (r_state == LOW && w_zero && !w_end)
            r_pulse_cnt <= r_pulse_cnt + BURST_W'(1);
      end
   end

   assign sample_adc = r_sample;
   assign busy       = r_busy;
   assign done       = r_done;
   assign pulse_cnt  = r_pulse_cnt;

endmodule

// File: tb/tb_sample_gen.sv
// tb_sample_gen: directed stimulus with a timeline model of sample_gen checked every cycle.
module tb_sample_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic [15:0] half_period = '0;
   logic [7:0]  burst_len = '0;
   logic       sample_adc, busy, done;
   logic [7:0] pulse_cnt;
`ifdef SAMPLE_GEN_EXT_TRIG_EN
   logic       ext_trig = 1'b0;
`endif

   sample_gen #(.CNT_W(16), .BURST_W(8)) dut (
`ifdef SAMPLE_GEN_EXT_TRIG_EN
      .ext_trig(ext_trig),
`endif
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .half_period(half_period), .burst_len(burst_len),
      .sample_adc(sample_adc), .busy(busy), .done(done), .pulse_cnt(pulse_cnt)
   );

   always #5 clk = ~clk;

   // Model: a run is a timeline from its start edge t0; outputs follow from elapsed cycles.
   int e = 0, t0 = 0, hp = 1, bl = 0, sl = 0, lim = 0, k = 0;
   bit run = 0, tg = 0, h1 = 0, h2 = 0, h3 = 0;
   bit m_sa = 0, m_busy = 0, m_done = 0;
   int m_pc = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         run = 0; m_sa = 0; m_busy = 0; m_done = 0; m_pc = 0;
         h1 = 0; h2 = 0; h3 = 0;
      end else begin
         e++;
         tg = h2 & ~h3;
`ifdef SAMPLE_GEN_EXT_TRIG_EN
         h3 = h2; h2 = h1; h1 = ext_trig;
`endif
         m_done = 0;
         if (!run) begin
            if ((start || tg) && !stop) begin
               run = 1; t0 = e; bl = int'(burst_len); sl = 0;
               hp = (half_period == 0) ? 1 : int'(half_period);
            end
         end else begin
            k = e - t0;
            lim = (bl != 0 && (sl == 0 || bl < sl)) ? bl : sl;
            if (lim != 0 && k == 2 * hp * lim) begin
               run = 0; m_done = 1;
            end else if (stop && sl == 0) begin
               sl = k / (2 * hp) + 1;
            end
         end
         m_busy = run;
         if (run) begin
            k = e - t0;
            m_sa = (k % (2 * hp)) < hp;
            m_pc = (k / (2 * hp) + 1) % 256;
         end else m_sa = 0;
      end
   end

   int errors = 0, checks = 0, cyc = 0, rises = 0, t_go = 0, len = 0, snap = 0;
   bit prev_sa = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick;
      @(negedge clk);
      cyc++;
      if (!rst) begin
         chk("model sample_adc", int'(sample_adc), int'(m_sa));
         chk("model busy", int'(busy), int'(m_busy));
         chk("model done", int'(done), int'(m_done));
         chk("model pulse_cnt", int'(pulse_cnt), m_pc);
      end
      if (sample_adc && !prev_sa) rises++;
      prev_sa = sample_adc;
   endtask

   task automatic go(input int h, input int b);
      half_period = 16'(h); burst_len = 8'(b); start = 1;
      snap = rises;
      tick;
      start = 0; half_period = 16'd9; burst_len = 8'd1;
      t_go = cyc;
   endtask

   task automatic wait_idle(input int max, input string name);
      for (int i = 0; i < max && busy; i++) tick;
      if (busy) begin
         errors++; checks++;
         $display("FAIL %s timeout: busy still 1 after %0d cycles", name, max);
      end
      len = cyc - t_go;
   endtask

   initial begin
      repeat (2) tick;
      chk("reset sample_adc", int'(sample_adc), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset done", int'(done), 0);
      chk("reset pulse_cnt", int'(pulse_cnt), 0);
      rst = 0;
      tick;
      // 1: burst of 4, hp=3
      go(3, 4);
      wait_idle(60, "burst");
      chk("burst length", len, 24);
      chk("burst done", int'(done), 1);
      chk("burst pulse_cnt", int'(pulse_cnt), 4);
      chk("burst rises", rises - snap, 4);
      tick;
      chk("burst done one cycle", int'(done), 0);
      // 2: continuous, stop inside 5th high phase
      go(2, 0);
      repeat (16) tick;
      stop = 1; tick; stop = 0;
      wait_idle(40, "stop");
      chk("stop length", cyc - t_go, 20);
      chk("stop pulse_cnt", int'(pulse_cnt), 5);
      chk("stop rises", rises - snap, 5);
      repeat (3) tick;
      // 3: zero half-period behaves as 1
      go(0, 2);
      wait_idle(20, "zero hp");
      chk("zero hp length", len, 4);
      chk("zero hp rises", rises - snap, 2);
      tick;
      // 4: collisions
      half_period = 16'd2; burst_len = 8'd1; start = 1; stop = 1;
      tick;
      start = 0; stop = 0;
      chk("start+stop busy", int'(busy), 0);
      tick;
      chk("start+stop done", int'(done), 0);
      go(5, 2);
      repeat (3) tick;
      half_period = 16'd7; start = 1; tick; start = 0;
      wait_idle(60, "busy start");
      chk("busy start length", len, 20);
      chk("busy start pulse_cnt", int'(pulse_cnt), 2);
      tick;
      // 5: async reset in HIGH
      go(4, 0);
      repeat (2) tick;
      #1 rst = 1;
      #1;
      chk("async rst sample_adc", int'(sample_adc), 0);
      chk("async rst busy", int'(busy), 0);
      chk("async rst pulse_cnt", int'(pulse_cnt), 0);
      tick;
      rst = 0;
      tick;
      go(1, 3);
      wait_idle(20, "after reset");
      chk("after reset length", len, 6);
      chk("after reset pulse_cnt", int'(pulse_cnt), 3);
      repeat (2) tick;
`ifdef SAMPLE_GEN_EXT_TRIG_EN
      // 6: external trigger, second rise while busy is ignored
      half_period = 16'd4; burst_len = 8'd1; ext_trig = 1;
      snap = rises; t_go = cyc;
      repeat (2) tick;
      chk("ext_trig not yet", int'(sample_adc), 0);
      tick;
      chk("ext_trig latency 3", int'(sample_adc), 1);
      tick;
      ext_trig = 0; repeat (2) tick; ext_trig = 1;
      wait_idle(40, "ext_trig");
      chk("ext_trig length", len, 11);
      chk("ext_trig rises", rises - snap, 1);
      ext_trig = 0;
      repeat (6) tick;
      chk("ext_trig stays idle", int'(busy), 0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
